// File: rtl/execute_stage.sv
// Execute stage: ADD/SUB/JALR/BEQ in one cycle, MUL via a 32-iteration shift-add
// engine that stalls upstream until the product is registered.
module execute_stage #(
  parameter int unsigned MUL_ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [4:0]  alu_operation,
  input  logic        dest_register_enable,
  input  logic [4:0]  dest_register_number,
  input  logic [31:0] in_passthrough_next_program_counter,
  input  logic [31:0] branch_dest,
  output logic [31:0] result,
  output logic        out_dest_register_enable,
  output logic [4:0]  out_dest_register_number,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        stall
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned REG_W = 5;

  localparam logic [4:0] ADDITION       = 5'd0;
  localparam logic [4:0] SUBTRACTION    = 5'd1;
  localparam logic [4:0] MULTIPLICATION = 5'd2;
  localparam logic [4:0] UNCOND_JUMP    = 5'd3;
  localparam logic [4:0] COND_EQ_JUMP   = 5'd4;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MUL_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITERATIONS - 1);

  logic [0:0]       state, state_n;
  logic [CNT_W-1:0] counter, counter_n;
  logic [XLEN-1:0]  multiplicand, multiplicand_n;
  logic [XLEN-1:0]  multiplier, multiplier_n;
  logic [XLEN-1:0]  accumulator, accumulator_n;
  logic             mul_dest_enable, mul_dest_enable_n;
  logic [REG_W-1:0] mul_dest_number, mul_dest_number_n;

  logic [XLEN-1:0]  result_n;
  logic             dest_enable_n;
  logic [REG_W-1:0] dest_number_n;
  logic             branch_taken_n;
  logic [XLEN-1:0]  branch_target_n;
  logic             stall_raw;

  logic [XLEN-1:0]  sum;
  logic [XLEN-1:0]  diff;
  logic [XLEN-1:0]  acc_step;

  assign sum      = operand1 + operand2;
  assign diff     = operand1 - operand2;
  assign acc_step = accumulator + (multiplier[0] ? multiplicand : XLEN'(0));

  // Next-state and registered-output values; anything unassigned is a bubble.
  always_comb begin
    state_n           = state;
    counter_n         = counter;
    multiplicand_n    = multiplicand;
    multiplier_n      = multiplier;
    accumulator_n     = accumulator;
    mul_dest_enable_n = mul_dest_enable;
    mul_dest_number_n = mul_dest_number;
    result_n          = '0;
    dest_enable_n     = 1'b0;
    dest_number_n     = '0;
    branch_taken_n    = 1'b0;
    branch_target_n   = '0;
    stall_raw         = 1'b0;

    case (state)
      IDLE: begin
        // A live branch_taken means the presented instruction is wrong-path.
        if (!branch_taken) begin
          if (alu_operation == MULTIPLICATION) begin
            stall_raw         = 1'b1;
            multiplicand_n    = operand1;
            multiplier_n      = operand2;
            accumulator_n     = '0;
            counter_n         = '0;
            mul_dest_enable_n = dest_register_enable;
            mul_dest_number_n = dest_register_number;
            state_n           = MUL_BUSY;
          end else begin
            dest_enable_n = dest_register_enable;
            dest_number_n = dest_register_number;
            case (alu_operation)
              SUBTRACTION: result_n = diff;
              UNCOND_JUMP: begin
                result_n        = in_passthrough_next_program_counter;
                branch_taken_n  = 1'b1;
                branch_target_n = {sum[XLEN-1:1], 1'b0};
              end
              COND_EQ_JUMP: begin
                branch_taken_n  = (operand1 == operand2);
                branch_target_n = branch_dest;
              end
              default: result_n = sum;
            endcase
          end
        end
      end

      MUL_BUSY: begin
        accumulator_n  = acc_step;
        multiplicand_n = multiplicand << 1;
        multiplier_n   = multiplier >> 1;
        counter_n      = counter + CNT_W'(1);
        // Last iteration folds its partial product straight into the result.
        if (counter == LAST_ITER) begin
          result_n      = acc_step;
          dest_enable_n = mul_dest_enable;
          dest_number_n = mul_dest_number;
          counter_n     = '0;
          state_n       = IDLE;
        end else begin
          stall_raw = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign stall = stall_raw & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      counter         <= '0;
      multiplicand    <= '0;
      multiplier      <= '0;
      accumulator     <= '0;
      mul_dest_enable <= 1'b0;
      mul_dest_number <= '0;
    end else begin
      state           <= state_n;
      counter         <= counter_n;
      multiplicand    <= multiplicand_n;
      multiplier      <= multiplier_n;
      accumulator     <= accumulator_n;
      mul_dest_enable <= mul_dest_enable_n;
      mul_dest_number <= mul_dest_number_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result                   <= '0;
      out_dest_register_enable <= 1'b0;
      out_dest_register_number <= '0;
      branch_taken             <= 1'b0;
      branch_target            <= '0;
    end else begin
      result                   <= result_n;
      out_dest_register_enable <= dest_enable_n;
      out_dest_register_number <= dest_number_n;
      branch_taken             <= branch_taken_n;
      branch_target            <= branch_target_n;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: single-cycle vector table plus MUL,
// squash and reset-during-multiply sequences.
module tb_execute_stage;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_JMP = 5'd3;
  localparam logic [4:0] OP_BEQ = 5'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] operand1, operand2;
  logic [4:0]  alu_operation;
  logic        dest_register_enable;
  logic [4:0]  dest_register_number;
  logic [31:0] in_passthrough_next_program_counter;
  logic [31:0] branch_dest;
  logic [31:0] result;
  logic        out_dest_register_enable;
  logic [4:0]  out_dest_register_number;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk),
    .reset(reset),
    .operand1(operand1),
    .operand2(operand2),
    .alu_operation(alu_operation),
    .dest_register_enable(dest_register_enable),
    .dest_register_number(dest_register_number),
    .in_passthrough_next_program_counter(in_passthrough_next_program_counter),
    .branch_dest(branch_dest),
    .result(result),
    .out_dest_register_enable(out_dest_register_enable),
    .out_dest_register_number(out_dest_register_number),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .stall(stall)
  );

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  op;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] bdest;
    logic [70:0] exp;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [70:0] rec(input logic [31:0] r, input logic en, input logic [4:0] rd,
                                      input logic bt, input logic [31:0] tgt);
    return {r, en, rd, bt, tgt};
  endfunction

  function automatic logic [70:0] outs();
    return {result, out_dest_register_enable, out_dest_register_number, branch_taken, branch_target};
  endfunction

  task automatic chk(input string name, input logic [70:0] got, input logic [70:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                       input logic en, input logic [4:0] rd, input logic [31:0] pc4,
                       input logic [31:0] bd);
    operand1 = a;
    operand2 = b;
    alu_operation = op;
    dest_register_enable = en;
    dest_register_number = rd;
    in_passthrough_next_program_counter = pc4;
    branch_dest = bd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one MUL from presentation to its registered result; leaves an ADD 2+3 -> x12 presented.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp);
    drive(a, b, OP_MUL, 1'b1, rd, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      #1;
      chk($sformatf("mul_stall_%0d", i), 71'(stall), 71'(1));
      step();
      chk($sformatf("mul_bubble_%0d", i), outs(), '0);
    end
    drive(32'd2, 32'd3, OP_ADD, 1'b1, 5'd12, 32'h0, 32'h0);
    #1;
    chk("mul_last_stall", 71'(stall), 71'(0));
    step();
    chk("mul_result", outs(), rec(exp, 1'b1, rd, 1'b0, 32'h0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'd7, 32'd5, OP_ADD, 1'b1, 5'd3, 32'h0, 32'h0, rec(32'd12, 1'b1, 5'd3, 1'b0, 32'h0)};
    vecs[1]  = '{32'd5, 32'd7, OP_SUB, 1'b1, 5'd5, 32'h0, 32'h0, rec(32'hFFFFFFFE, 1'b1, 5'd5, 1'b0, 32'h0)};
    vecs[2]  = '{32'd9, 32'd9, OP_BEQ, 1'b0, 5'd0, 32'h0, 32'h100, rec(32'h0, 1'b0, 5'd0, 1'b1, 32'h100)};
    vecs[3]  = '{32'd1, 32'd2, OP_ADD, 1'b1, 5'd6, 32'h0, 32'h0, rec(32'h0, 1'b0, 5'd0, 1'b0, 32'h0)};
    vecs[4]  = '{32'd9, 32'd8, OP_BEQ, 1'b0, 5'd0, 32'h0, 32'h180, rec(32'h0, 1'b0, 5'd0, 1'b0, 32'h180)};
    vecs[5]  = '{32'd3, 32'd4, OP_ADD, 1'b1, 5'd7, 32'h0, 32'h0, rec(32'd7, 1'b1, 5'd7, 1'b0, 32'h0)};
    vecs[6]  = '{32'h200, 32'h11, OP_JMP, 1'b1, 5'd1, 32'h48, 32'h0, rec(32'h48, 1'b1, 5'd1, 1'b1, 32'h210)};
    vecs[7]  = '{32'd5, 32'd5, OP_ADD, 1'b1, 5'd9, 32'h0, 32'h0, rec(32'h0, 1'b0, 5'd0, 1'b0, 32'h0)};
    vecs[8]  = '{32'd10, 32'd20, 5'd31, 1'b1, 5'd2, 32'h0, 32'h0, rec(32'd30, 1'b1, 5'd2, 1'b0, 32'h0)};
    vecs[9]  = '{32'hFFFFFFFF, 32'd2, OP_ADD, 1'b1, 5'd10, 32'h0, 32'h0, rec(32'd1, 1'b1, 5'd10, 1'b0, 32'h0)};
    vecs[10] = '{32'h301, 32'h0, OP_JMP, 1'b0, 5'd0, 32'h60, 32'h0, rec(32'h60, 1'b0, 5'd0, 1'b1, 32'h300)};
    vecs[11] = '{32'd0, 32'd1, OP_SUB, 1'b1, 5'd11, 32'h0, 32'h0, rec(32'h0, 1'b0, 5'd0, 1'b0, 32'h0)};
    vecs[12] = '{32'd0, 32'd1, OP_SUB, 1'b1, 5'd11, 32'h0, 32'h0, rec(32'hFFFFFFFF, 1'b1, 5'd11, 1'b0, 32'h0)};

    reset = 1'b1;
    drive(32'h0, 32'h0, OP_ADD, 1'b0, 5'd0, 32'h0, 32'h0);
    step();
    chk("reset_outputs", outs(), '0);
    chk("reset_stall", 71'(stall), 71'(0));
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op1, vecs[i].op2, vecs[i].op, vecs[i].en, vecs[i].rd, vecs[i].pc4, vecs[i].bdest);
      #1;
      chk($sformatf("vec%0d_stall", i), 71'(stall), 71'(0));
      step();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Back-to-back MULs, then the ADD left at the inputs executes.
    do_mul(32'hFFFFFFFF, 32'd3, 5'd4, 32'hFFFFFFFD);
    do_mul(32'd6, 32'd7, 5'd8, 32'd42);
    step();
    chk("add_after_mul", outs(), rec(32'd5, 1'b1, 5'd12, 1'b0, 32'h0));

    // Taken branch followed by MUL: squashed, no stall.
    drive(32'd4, 32'd4, OP_BEQ, 1'b0, 5'd0, 32'h0, 32'h40);
    step();
    chk("beq_before_mul", outs(), rec(32'h0, 1'b0, 5'd0, 1'b1, 32'h40));
    drive(32'd3, 32'd3, OP_MUL, 1'b1, 5'd13, 32'h0, 32'h0);
    #1;
    chk("squashed_mul_stall", 71'(stall), 71'(0));
    drive(32'd8, 32'd1, OP_ADD, 1'b1, 5'd14, 32'h0, 32'h0);
    step();
    chk("squashed_mul_bubble", outs(), '0);
    step();
    chk("add_after_squash", outs(), rec(32'd9, 1'b1, 5'd14, 1'b0, 32'h0));

    // Reset during iteration 10 of a multiply.
    drive(32'd1000, 32'd1000, OP_MUL, 1'b1, 5'd15, 32'h0, 32'h0);
    for (int i = 0; i < 11; i++) step();
    chk("mul_midway_stall", 71'(stall), 71'(1));
    reset = 1'b1;
    #1;
    chk("reset_mid_mul_outputs", outs(), '0);
    chk("reset_mid_mul_stall", 71'(stall), 71'(0));
    step();
    reset = 1'b0;
    drive(32'd1, 32'd1, OP_ADD, 1'b1, 5'd16, 32'h0, 32'h0);
    #1;
    chk("post_reset_stall", 71'(stall), 71'(0));
    step();
    chk("post_reset_add", outs(), rec(32'd2, 1'b1, 5'd16, 1'b0, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the in-order RISC-V pipeline. It sits directly downstream of the decode stage and consumes its registered operands, ALU operation, destination and PC fields. It produces a registered writeback record and resolves BEQ/JALR into a one-cycle redirect pulse for fetch. Multiplication runs on a 32-iteration shift-add state machine, and the stage stalls upstream until the product is ready.

## Interface
Parameters:
- MUL_ITERATIONS, 32, number of shift-add iterations per multiply. Fixed at 32 for RV32; other values are unsupported.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- operand1  input  32  rs1 value from decode.
- operand2  input  32  rs2 value or sign-extended immediate from decode.
- alu_operation  input  5  ADDITION / SUBTRACTION / MULTIPLICATION / UNCOND_JUMP / COND_EQ_JUMP (ALU constants); any other code executes as ADDITION.
- dest_register_enable  input  1  instruction writes rd.
- dest_register_number  input  5  rd.
- in_passthrough_next_program_counter  input  32  PC+4 of the instruction (link value).
- branch_dest  input  32  PC + B-immediate, precomputed by decode.
- result  output  32  registered ALU result or link value.
- out_dest_register_enable  output  1  registered writeback enable.
- out_dest_register_number  output  5  registered rd.
- branch_taken  output  1  registered one-cycle redirect pulse; also drives kill_instr of decode.
- branch_target  output  32  registered redirect address, valid while branch_taken is high.
- stall  output  1  combinational; upstream stages hold their registers while it is high.

## Operation
- The state machine has two states, IDLE and MUL_BUSY. A 5-bit iteration counter runs 0..31.
- Squash: when branch_taken is currently high, the instruction at the inputs is wrong-path and is treated as a bubble.
  - A bubble writes 0 to out_dest_register_enable, out_dest_register_number, result, branch_taken and branch_target.
  - A squashed MUL does not start and does not raise stall.
- IDLE, non-MUL instruction: on the next edge the stage registers the result, enable and rd.
  - ADDITION: operand1+operand2, mod 2^32.
  - SUBTRACTION: operand1-operand2, mod 2^32.
  - UNCOND_JUMP (JALR): result = in_passthrough_next_program_counter; branch_taken = 1; branch_target = (operand1+operand2) with bit 0 forced to 0.
  - COND_EQ_JUMP (BEQ): branch_taken = (operand1 == operand2); branch_target = branch_dest. Enable and rd pass through unchanged (decode already sends 0 and x0). result = 0.
- IDLE, MUL instruction that is not squashed:
  - stall = 1 combinationally.
  - On the edge, load multiplicand = operand1, multiplier = operand2, accumulator = 0, counter = 0, and latch dest enable/rd internally.
  - Go to MUL_BUSY. Outputs register a bubble.
- MUL_BUSY, each edge:
  - If multiplier[0] is 1, accumulator += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; counter += 1.
  - Outputs register a bubble.
- MUL_BUSY when counter == 31:
  - stall = 0 in this cycle.
  - On the edge, result = the final accumulator (low 32 bits of the product) and the latched enable/rd are registered. The state returns to IDLE.
  - The inputs present at this edge are not executed; they are evaluated in IDLE on the following cycle.
- stall = (IDLE && MULTIPLICATION && !branch_taken) || (MUL_BUSY && counter != 31). stall is forced to 0 while reset is high.

## Timing
- Reset values: result = 0, out_dest_register_enable = 0, out_dest_register_number = 0 (x0), branch_taken = 0, branch_target = 0, stall = 0, state IDLE, counter = 0, accumulator = 0.
- Reset asserted during MUL_BUSY abandons the multiply. The first post-reset instruction starts in IDLE.
- Latency for non-MUL operations is 1 cycle, from the input being presented to the registered output.
- MUL latency is 33 edges from the instruction first being presented. stall is high for 32 cycles.
- branch_taken is high for exactly one cycle per taken branch. Fetch must redirect to branch_target on that cycle, and decode kills its current instruction.
- A taken branch followed by a MUL: the MUL is squashed; branch_taken stays one cycle; there is no stall.
- Back-to-back MULs: the second MUL starts in IDLE on the cycle after the first one's result is registered. Its stall rises combinationally as soon as it is presented.

## Test plan
- ADD 7+5 with rd=x3, enable=1 -> next cycle result=12, out_dest_register_enable=1, out_dest_register_number=3. SUB 5-7 -> result=0xFFFFFFFE.
- MUL 0xFFFFFFFF*3 with rd=x4 -> stall high for 32 cycles; on edge 33 result=0xFFFFFFFD with enable=1 and rd=4; all intermediate outputs are bubbles.
- BEQ with operand1 = operand2 = 9 and branch_dest=0x100 -> branch_taken=1 for one cycle, branch_target=0x100, result=0, enable=0. The following input ADD is squashed (enable=0).
- BEQ with 9 vs 8 -> branch_taken=0. The next ADD executes normally.
- JALR with operand1=0x200, operand2=0x11, passthrough=0x48, rd=x1 -> result=0x48, enable=1, branch_taken=1, branch_target=0x210.
- Reset asserted at iteration 10 of a MUL -> all outputs 0 immediately and stall=0. After release, ADD 1+1 gives result=2 on the next cycle.
